mem_arbiter: RTL and testbench

- Shares the single multicycle main memory between the I-cache fill FSM and the D-cache (fill FSM plus write-through stores).
- Grants one requester at a time and holds the grant for a whole 8-beat block fill or a single-cycle write.
- Routes the memory data-valid strobe only to the granted requester.
- Asserts busy so the pipeline can stall the loser.

---
 rtl/mem_arbiter.sv | 72 +++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants main memory to the I-cache or D-cache for a whole block fill or one write
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int BEATS  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic              ic_data_valid,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_gnt,
  output logic              dc_data_valid,
  output logic              dc_wr_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_data_valid,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;
  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] issue_cnt, ret_cnt;
  logic last_d;
  logic fill, done;
  assign fill = state == I_FILL || state == D_FILL;
  assign done = fill && mem_data_valid && ret_cnt == LAST_C;
  // outputs decoded from the registered state; returns outside a fill are dropped
  always_comb begin
    ic_gnt        = state == I_FILL;
    dc_gnt        = state == D_FILL || state == D_WRITE;
    busy          = state != IDLE;
    ic_data_valid = state == I_FILL && mem_data_valid;
    dc_data_valid = state == D_FILL && mem_data_valid;
    dc_wr_done    = state == D_WRITE;
    mem_wr        = state == D_WRITE;
    mem_en        = fill ? issue_cnt < BEATS_C : state == D_WRITE;
    mem_addr      = !mem_en ? '0 : state == I_FILL ? ic_addr : dc_addr;
    mem_wdata     = mem_wr ? dc_wdata : '0;
  end
  // arbitration in IDLE alternates on ties; a fill ends on its last return, a write after one cycle
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = dc_req && (!ic_req || !last_d) ? (dc_we ? D_WRITE : D_FILL) : ic_req ? I_FILL : IDLE;
    else if (state == D_WRITE || done)
      state_nx = IDLE;
  end
  // state, saturating beat counters cleared while idle, and the last-served side
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      last_d    <= 1'b0;
    end else begin
      state     <= state_nx;
      issue_cnt <= state == IDLE ? '0 : issue_cnt + CNT_W'(fill && issue_cnt < BEATS_C);
      ret_cnt   <= state == IDLE ? '0 : ret_cnt + CNT_W'(fill && mem_data_valid && ret_cnt < BEATS_C);
      if (state == D_WRITE || done) last_d <= state != I_FILL;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int BEATS = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0;
  logic [15:0] ic_addr = '0, dc_addr = '0, dc_wdata = '0;
  logic ic_gnt, ic_data_valid, dc_gnt, dc_data_valid, dc_wr_done;
  logic mem_en, mem_wr, mem_data_valid, busy;
  logic [15:0] mem_addr, mem_wdata;
  logic [3:0] pipe = '0;
  logic [39:0] obs;
  int n_cmp = 0, n_bad = 0;
  bit mon = 1'b0;
  int m_own = 0, m_iss = 0, m_ret = 0;
  bit m_last_d = 1'b0;
  int en_cnt, icv, dcv, wr_cnt, t_ic0, t_ic1, t_dc0, t_wr, t_fall, stray, stray_dv;
  logic [15:0] last_addr;
  int seq[$];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_data_valid(ic_data_valid),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_gnt(dc_gnt), .dc_data_valid(dc_data_valid), .dc_wr_done(dc_wr_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_valid(mem_data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // memory returns read data four cycles after each read enable, regardless of reset
  always @(posedge clk) pipe <= {pipe[2:0], mem_en & ~mem_wr};
  assign mem_data_valid = pipe[3];

  assign obs = {busy, ic_gnt, ic_data_valid, dc_gnt, dc_data_valid, dc_wr_done, mem_en, mem_wr, mem_addr, mem_wdata};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // model owner: 0 nobody, 1 I-cache fill, 2 D-cache fill, 3 D-cache write
  always @(posedge clk) begin
    if (rst) begin
      m_own <= 0; m_iss <= 0; m_ret <= 0; m_last_d <= 1'b0;
    end else if (m_own == 0) begin
      m_iss <= 0; m_ret <= 0;
      if (dc_req && !(ic_req && m_last_d)) m_own <= dc_we ? 3 : 2;
      else if (ic_req) m_own <= 1;
    end else if (m_own == 3) begin
      m_own <= 0; m_last_d <= 1'b1;
    end else begin
      if (m_iss < BEATS) m_iss <= m_iss + 1;
      if (mem_data_valid) begin
        m_ret <= m_ret + 1;
        if (m_ret + 1 == BEATS) begin m_own <= 0; m_last_d <= m_own == 2; end
      end
    end
  end

  function automatic logic [39:0] expv();
    logic en, wr;
    logic [15:0] a, d;
    wr = m_own == 3;
    en = (m_own == 1 || m_own == 2) ? m_iss < BEATS : wr;
    a = !en ? 16'h0 : m_own == 1 ? ic_addr : dc_addr;
    d = wr ? dc_wdata : 16'h0;
    return {m_own != 0, m_own == 1, m_own == 1 && mem_data_valid, m_own >= 2,
            m_own == 2 && mem_data_valid, wr, en, wr, a, d};
  endfunction

  always @(negedge clk) if (mon) chk("cyc", obs, expv());

  task automatic pulse_rst();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run(input int n, input bit auto_drop);
    bit pb, dic, ddc, step;
    en_cnt = 0; icv = 0; dcv = 0; wr_cnt = 0;
    t_ic0 = -1; t_ic1 = -1; t_dc0 = -1; t_wr = -1; t_fall = -1;
    seq.delete();
    pb = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mem_en) begin en_cnt++; last_addr = mem_addr; end
      if (ic_gnt) begin if (t_ic0 < 0) t_ic0 = i; t_ic1 = i; end
      if (dc_gnt && t_dc0 < 0) t_dc0 = i;
      if (busy && !pb) seq.push_back(ic_gnt ? 1 : 2);
      if (!busy && pb && t_fall < 0) t_fall = i;
      dic = auto_drop && ic_data_valid && icv % BEATS == BEATS - 1;
      ddc = auto_drop && ((dc_data_valid && dcv % BEATS == BEATS - 1) || dc_wr_done);
      if (ic_data_valid) icv++;
      if (dc_data_valid) dcv++;
      if (dc_wr_done) begin wr_cnt++; t_wr = i; end
      step = ic_gnt && mem_en;
      pb = busy;
      @(posedge clk);
      #1;
      if (step) ic_addr = ic_addr + 16'd2;
      if (dic) ic_req = 1'b0;
      if (ddc) dc_req = 1'b0;
    end
  endtask

  initial begin
    @(posedge clk);
    mon = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_idle", obs, 40'h0);
    end
    @(posedge clk);
    #1;
    // I-cache block fill with a stepping address
    ic_addr = 16'h0310; ic_req = 1'b1;
    run(20, 1'b1);
    chk("ic_first_gnt", t_ic0, 1);
    chk("ic_en_cnt", en_cnt, 8);
    chk("ic_last_addr", last_addr, 16'h031E);
    chk("ic_valids", icv, 8);
    chk("ic_no_dc_valid", dcv, 0);
    chk("ic_busy_fall", t_fall, 13);
    // simultaneous fill requests straight after reset: D first, then alternate
    pulse_rst();
    ic_addr = 16'h2000; dc_addr = 16'h3000; dc_we = 1'b0;
    ic_req = 1'b1; dc_req = 1'b1;
    run(30, 1'b0);
    chk("tie_first_d", t_dc0, 1);
    chk("tie_then_i", t_ic0, 14);
    chk("tie_count", seq.size(), 3);
    chk("tie_seq0", seq[0], 2);
    chk("tie_seq1", seq[1], 1);
    chk("tie_seq2", seq[2], 2);
    ic_req = 1'b0; dc_req = 1'b0;
    run(20, 1'b0);
    // single-word store
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 16'h1234; dc_wdata = 16'hBEEF;
    @(negedge clk);
    chk("wr_wait", busy, 1'b0);
    @(posedge clk);
    #1 dc_req = 1'b0;
    @(negedge clk);
    chk("wr_cycle", obs, 40'h97_1234_BEEF);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("wr_back_idle", obs, 40'h0);
    @(posedge clk);
    #1;
    // store arriving during an I-cache fill waits for the fill plus one idle cycle
    ic_addr = 16'h0400; ic_req = 1'b1;
    run(3, 1'b1);
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 16'h5555; dc_wdata = 16'h0A0A;
    run(30, 1'b1);
    chk("blk_wr_once", wr_cnt, 1);
    chk("blk_wr_after_gap", t_wr, t_ic1 + 2);
    chk("blk_ic_valids", icv, 8);
    chk("blk_ic_last", t_ic1, 9);
    // reset in the middle of a D-cache fill; later returns are strays
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 16'h0700;
    dcv = 0;
    for (int i = 0; i < 40 && dcv < 3; i++) begin
      @(negedge clk);
      if (dc_data_valid) dcv++;
      @(posedge clk);
      #1;
    end
    chk("rst_mid_beats", dcv, 3);
    rst = 1'b1; dc_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    stray = 0; stray_dv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) chk("rst_mid_idle", obs, 40'h0);
      stray += int'(mem_data_valid);
      stray_dv += int'(ic_data_valid) + int'(dc_data_valid);
    end
    chk("stray_seen", stray > 0, 1'b1);
    chk("stray_dropped", stray_dv, 0);
    @(posedge clk);
    #1;
    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 249) == 0;
      if ($urandom_range(0, 5) == 0) ic_req = ~ic_req;
      if ($urandom_range(0, 5) == 0) dc_req = ~dc_req;
      dc_we = $urandom_range(0, 1) == 1;
      ic_addr = 16'($urandom);
      dc_addr = 16'($urandom);
      dc_wdata = 16'($urandom);
      @(posedge clk);
      #1;
    end
    ic_req = 1'b0; dc_req = 1'b0; rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    @(negedge clk);
    chk("end_idle", busy, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
